// File: rtl/serial_encoder.sv
// -----------------------------------------------------------------------------
// serial_encoder
//
// Sequential N-to-log2(N) encoder. A multi-hot request vector is accepted over
// a valid/ready handshake. The binary index of every set bit is then emitted,
// one index per output beat, in a fixed priority order. Both sides support full
// backpressure.
//
// Optional build macro:
//   ENC_MSB_FIRST_EN - when defined, the highest-numbered set bit is emitted
//                      first, so indices within a burst are strictly
//                      decreasing. When undefined (the default), bit 0 has the
//                      highest priority and indices are strictly increasing.
//
// Parameters:
//   N          input vector width (power of two, N >= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_vec is valid
//   in_ready   encoder can accept a vector (high only while idle)
//   in_vec     request vector; bit i set means index i is to be emitted
//   out_valid  out_idx / out_last are valid
//   out_ready  consumer accepts the current beat
//   out_idx    binary index of the currently selected set bit
//   out_last   current beat is the final one for this vector
//   err_zero   one-cycle pulse: an all-zero vector was accepted and dropped
// -----------------------------------------------------------------------------
module serial_encoder #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 err_zero
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [N-1:0]    pending_q;
  logic [N-1:0]    pending_d;
  logic            out_valid_d;
  logic [IW-1:0]   out_idx_d;
  logic            out_last_d;
  logic            err_zero_d;
  logic [N-1:0]    beat_mask;

  // Select the bit of a pending vector that goes out next. The loop runs
  // towards the highest-priority bit, so the last hit found is the winner.
  function automatic logic [IW-1:0] pick_index(input logic [N-1:0] vec);
    logic [IW-1:0] idx;
    idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = IW'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
`endif
    return idx;
  endfunction

  // True when exactly one bit is set. Clearing the lowest set bit of a
  // one-hot vector leaves zero.
  function automatic logic is_single(input logic [N-1:0] vec);
    return (vec != '0) && ((vec & (vec - N'(1))) == '0);
  endfunction

  // The index on out_idx always names the bit that the current beat retires.
  // Decoding it back to a mask therefore gives the bit to clear on handshake.
  assign beat_mask = N'(1) << out_idx;

  // The handshake depends only on the state register, so in_ready stays high
  // throughout reset.
  assign in_ready = (state_q == IDLE);

  // Next-state logic. The output registers are derived from the next pending
  // vector, so each new beat is visible in the cycle right after the edge
  // that produced it. This holds for the first beat after accept and for every
  // following beat of a burst.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    err_zero_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != '0) begin
            pending_d = in_vec;
            state_d   = EMIT;
          end else begin
            err_zero_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d = pending_q & ~beat_mask;
          if (out_last) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase

    out_valid_d = (state_d == EMIT);
    out_idx_d   = out_valid_d ? pick_index(pending_d) : '0;
    out_last_d  = out_valid_d && is_single(pending_d);
  end

  // State, pending vector and all registered outputs. An asynchronous reset
  // discards any burst in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      err_zero  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      out_valid <= out_valid_d;
      out_idx   <= out_idx_d;
      out_last  <= out_last_d;
      err_zero  <= err_zero_d;
    end
  end

endmodule
